truth_table_sweeper: RTL and testbench

//  Sequencer for a small combinational function block with N_IN inputs and 1 output.
//  On start, it drives every input vector 0..2**N_IN-1 in ascending order and waits SETTLE cycles per vector.
//  It captures the output, compares it with a latched expected truth table, then reports pass/fail and a per-vector mismatch map.

---
 rtl/truth_table_sweeper_pkg.sv | 22 ++
 rtl/truth_table_sweeper_if.sv | 40 ++++
 rtl/truth_table_sweeper_settle_timer.sv | 43 ++++
 rtl/truth_table_sweeper.sv | 187 ++++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// ---------------------------------------------------------------------------
// sweeper_pkg
// Shared types and helpers for the truth-table sweeper.
//   sweep_state_t  : sequencer states IDLE -> SETTLE -> SAMPLE -> FINISH
//   sweep_latency  : cycles from the accepted start edge to the done pulse
// ---------------------------------------------------------------------------
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } sweep_state_t;

  // Every vector spends settle cycles settling plus one sample cycle, and the
  // done pulse lands one cycle after the last sample.
  function automatic int sweep_latency(input int n_in, input int settle);
    return (1 << n_in) * (settle + 1) + 1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper_if
// Bundles the control and function-side signals of the sweeper.
//   start, abort   : sweep control from the control source
//   expected       : golden truth table, bit k = required y for stim == k
//   y_in           : output of the combinational function under control
//   stim           : registered input vector driven into the function
//   busy, done     : sweep in progress / one-cycle completion pulse
//   pass           : last completed sweep had no mismatches
//   result         : captured y per vector
//   mismatch       : result ^ latched expected, bit per vector
// master = control source / bench side, slave = sweeper side.
// ---------------------------------------------------------------------------
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int DEPTH = 2 ** N_IN;

  logic             start;
  logic             abort;
  logic [DEPTH-1:0] expected;
  logic             y_in;
  logic [N_IN-1:0]  stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [DEPTH-1:0] result;
  logic [DEPTH-1:0] mismatch;

  modport master (
    output start, abort, expected, y_in,
    input  stim, busy, done, pass, result, mismatch
  );

  modport slave (
    input  start, abort, expected, y_in,
    output stim, busy, done, pass, result, mismatch
  );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// ---------------------------------------------------------------------------
// sweep_settle_timer
// 4-bit down-counter that times how long each stimulus vector is held.
//   clk, rst_n  : clock / asynchronous active-low reset
//   load_i      : load loadVal_i (wins over en_i)
//   loadVal_i   : value to load, the settle count minus one
//   en_i        : count down by one while nonzero
//   zero_o      : counter is at zero
// ---------------------------------------------------------------------------
module sweep_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] loadVal_i,
  input  logic       en_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Load has priority; the count saturates at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = loadVal_i;
    end else if (en_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
// Walks every input vector 0..2**N_IN-1 into a small combinational function,
// holds each one for SETTLE cycles, samples the function output, and compares
// it against a truth table latched when the sweep starts.
//   clk, rst_n : clock / asynchronous active-low reset
//   bus        : truth_table_sweeper_if slave (start, abort, expected, y_in in;
//                stim, busy, done, pass, result, mismatch out)
// Parameters: N_IN stimulus width, SETTLE hold cycles before sampling (1..15).
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);
  // The state named SETTLE collides with the parameter of the same name, so
  // that state is always written with its package prefix below.
  import sweeper_pkg::*;

  localparam int              DEPTH       = 2 ** N_IN;
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [N_IN:0]   LAST_IDX    = (N_IN + 1)'(DEPTH - 1);

  sweep_state_t     state_q, state_d;
  logic [N_IN:0]    idx_q, idx_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic [DEPTH-1:0] expLatched_q, expLatched_d;
  logic [DEPTH-1:0] result_q, result_d;
  logic [DEPTH-1:0] mismatch_q, mismatch_d;
  logic             pass_q, pass_d;

  logic acceptStart;
  logic lastVec;
  logic settleZero;
  logic timerLoad;
  logic timerEn;
  logic sweepBusy;
  logic sweepDone;

  // Abort beats start when both arrive in the same idle cycle.
  assign acceptStart = bus.start & ~bus.abort;
  // idx carries one spare bit so this compare never sees a wrapped index.
  assign lastVec     = (idx_q == LAST_IDX);

  sweep_settle_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (timerLoad),
    .loadVal_i (SETTLE_LOAD),
    .en_i      (timerEn),
    .zero_o    (settleZero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; FINISH always falls back to IDLE so an abort there
  // cannot swallow the done pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (acceptStart) state_d = sweeper_pkg::SETTLE;
      end
      sweeper_pkg::SETTLE: begin
        if (bus.abort)       state_d = IDLE;
        else if (settleZero) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (bus.abort)    state_d = IDLE;
        else if (lastVec) state_d = FINISH;
        else              state_d = sweeper_pkg::SETTLE;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and timer-control decode from the current state.
  always_comb begin
    sweepBusy = 1'b0;
    sweepDone = 1'b0;
    timerLoad = 1'b0;
    timerEn   = 1'b0;
    case (state_q)
      IDLE: begin
        timerLoad = acceptStart;
      end
      sweeper_pkg::SETTLE: begin
        sweepBusy = 1'b1;
        timerEn   = ~settleZero;
      end
      SAMPLE: begin
        sweepBusy = 1'b1;
        timerLoad = ~bus.abort & ~lastVec;
      end
      FINISH: begin
        sweepDone = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: latch the table on start, capture on the SAMPLE
  // exit edge, and fold the final compare into pass while in FINISH.
  always_comb begin
    idx_d        = idx_q;
    stim_d       = stim_q;
    expLatched_d = expLatched_q;
    result_d     = result_q;
    mismatch_d   = mismatch_q;
    pass_d       = pass_q;
    case (state_q)
      IDLE: begin
        if (acceptStart) begin
          idx_d        = '0;
          stim_d       = '0;
          expLatched_d = bus.expected;
          result_d     = '0;
          mismatch_d   = '0;
          pass_d       = 1'b0;
        end
      end
      sweeper_pkg::SETTLE: begin
        if (bus.abort) begin
          idx_d  = '0;
          stim_d = '0;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          idx_d  = '0;
          stim_d = '0;
        end else begin
          result_d[idx_q[N_IN-1:0]]   = bus.y_in;
          mismatch_d[idx_q[N_IN-1:0]] = bus.y_in ^ expLatched_q[idx_q[N_IN-1:0]];
          if (!lastVec) begin
            idx_d  = idx_q + 1'b1;
            stim_d = idx_d[N_IN-1:0];
          end
        end
      end
      FINISH: begin
        pass_d = (mismatch_q == '0);
        idx_d  = '0;
        stim_d = '0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      stim_q       <= '0;
      expLatched_q <= '0;
      result_q     <= '0;
      mismatch_q   <= '0;
      pass_q       <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      stim_q       <= stim_d;
      expLatched_q <= expLatched_d;
      result_q     <= result_d;
      mismatch_q   <= mismatch_d;
      pass_q       <= pass_d;
    end
  end

  assign bus.stim     = stim_q;
  assign bus.busy     = sweepBusy;
  assign bus.done     = sweepDone;
  assign bus.pass     = pass_q;
  assign bus.result   = result_q;
  assign bus.mismatch = mismatch_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper
// Drives two sweepers (SETTLE=2 and SETTLE=1) against the reference function
// y = (stim==2)||(stim==5) and checks done timing, stim stepping, pass,
// result and mismatch against hand-computed values.
// ---------------------------------------------------------------------------
module tb_truth_table_sweeper;

  typedef struct {
    logic [7:0] expTable;
    logic       expPass;
    logic [7:0] expResult;
    logic [7:0] expMismatch;
    int         expDone;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       startReq;
  logic       abortReq;
  logic       useSettle1;
  logic [7:0] expReq;

  int vecCount  = 0;
  int missCount = 0;

  logic [2:0] mStim;
  logic       mBusy, mDone, mPass;
  logic [7:0] mResult, mMismatch;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) bus0 ();
  truth_table_sweeper_if #(.N_IN(3)) bus1 ();

  // Control fans out to whichever sweeper is selected.
  assign bus0.start    = startReq & ~useSettle1;
  assign bus1.start    = startReq &  useSettle1;
  assign bus0.abort    = abortReq & ~useSettle1;
  assign bus1.abort    = abortReq &  useSettle1;
  assign bus0.expected = expReq;
  assign bus1.expected = expReq;

  // Reference combinational function.
  assign bus0.y_in = (bus0.stim == 3'd2) || (bus0.stim == 3'd5);
  assign bus1.y_in = (bus1.stim == 3'd2) || (bus1.stim == 3'd5);

  assign mStim     = useSettle1 ? bus1.stim     : bus0.stim;
  assign mBusy     = useSettle1 ? bus1.busy     : bus0.busy;
  assign mDone     = useSettle1 ? bus1.done     : bus0.done;
  assign mPass     = useSettle1 ? bus1.pass     : bus0.pass;
  assign mResult   = useSettle1 ? bus1.result   : bus0.result;
  assign mMismatch = useSettle1 ? bus1.mismatch : bus0.mismatch;

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    vecCount++;
    if (actual !== required) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Full sweep: pulse start, then watch done and the stim/busy stepping.
  task automatic applyStimulus(input logic [7:0] expTable, input int settle,
                               output int doneCycle, output int doneCount,
                               output int seqErrs);
    int sweepLen;
    sweepLen = 8 * (settle + 1);
    @(negedge clk);
    expReq   = expTable;
    startReq = 1'b1;
    @(posedge clk);
    #1 startReq = 1'b0;
    doneCycle = -1;
    doneCount = 0;
    seqErrs   = 0;
    for (int c = 1; c <= sweepLen + 4; c++) begin
      @(negedge clk);
      if (mDone) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      if (c <= sweepLen) begin
        if ((mStim !== 3'((c - 1) / (settle + 1))) || (mBusy !== 1'b1)) seqErrs++;
      end else if (c == sweepLen + 1) begin
        if (mBusy !== 1'b0) seqErrs++;
      end
    end
  endtask

  // Sweep with injected events at given cycles after the start edge.
  task automatic runCustom(input logic [7:0] expTable, input int restartC,
                           input int expChgC, input int abortC,
                           output int doneCycle, output int doneCount);
    @(negedge clk);
    expReq   = expTable;
    startReq = 1'b1;
    @(posedge clk);
    #1 startReq = 1'b0;
    doneCycle = -1;
    doneCount = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mDone) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      startReq = (c == restartC);
      abortReq = (c == abortC);
      if (c == expChgC) expReq = 8'hFF;
    end
    startReq = 1'b0;
    abortReq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [5];
    int   dc, dn, se;
    bit   found;

    tbl[0] = '{8'h24, 1'b1, 8'h24, 8'h00, 25};
    tbl[1] = '{8'h25, 1'b0, 8'h24, 8'h01, 25};
    tbl[2] = '{8'hDB, 1'b0, 8'h24, 8'hFF, 25};
    tbl[3] = '{8'hA4, 1'b0, 8'h24, 8'h80, 25};
    tbl[4] = '{8'h00, 1'b0, 8'h24, 8'h24, 25};

    rst_n      = 1'b0;
    startReq   = 1'b0;
    abortReq   = 1'b0;
    useSettle1 = 1'b0;
    expReq     = 8'h00;

    // Reset values.
    #12;
    checkOutput("rst_stim", 32'(mStim), 32'h0);
    checkOutput("rst_busy", 32'(mBusy), 32'h0);
    checkOutput("rst_done", 32'(mDone), 32'h0);
    checkOutput("rst_pass", 32'(mPass), 32'h0);
    checkOutput("rst_result", 32'(mResult), 32'h0);
    checkOutput("rst_mismatch", 32'(mMismatch), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven full sweeps.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(tbl[i].expTable, 2, dc, dn, se);
      checkOutput($sformatf("tbl%0d_doneCycle", i), 32'(dc), 32'(tbl[i].expDone));
      checkOutput($sformatf("tbl%0d_doneCount", i), 32'(dn), 32'd1);
      checkOutput($sformatf("tbl%0d_stimSeq", i), 32'(se), 32'd0);
      checkOutput($sformatf("tbl%0d_pass", i), 32'(mPass), 32'(tbl[i].expPass));
      checkOutput($sformatf("tbl%0d_result", i), 32'(mResult), 32'(tbl[i].expResult));
      checkOutput($sformatf("tbl%0d_mismatch", i), 32'(mMismatch), 32'(tbl[i].expMismatch));
    end

    // Start and abort together in IDLE: stays idle.
    @(negedge clk);
    startReq = 1'b1;
    abortReq = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("startAbort_busy", 32'(mBusy), 32'h0);
    end
    startReq = 1'b0;
    abortReq = 1'b0;

    // Good sweep so pass is 1, then abort when stim reaches 3.
    applyStimulus(8'h24, 2, dc, dn, se);
    checkOutput("preAbort_pass", 32'(mPass), 32'h1);
    @(negedge clk);
    expReq   = 8'h24;
    startReq = 1'b1;
    @(posedge clk);
    #1 startReq = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (mStim == 3'd3) found = 1'b1;
    end
    checkOutput("abort_reachStim3", 32'(found), 32'h1);
    abortReq = 1'b1;
    @(negedge clk);
    abortReq = 1'b0;
    checkOutput("abort_busy", 32'(mBusy), 32'h0);
    checkOutput("abort_stim", 32'(mStim), 32'h0);
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mDone) dn++;
    end
    checkOutput("abort_noDone", 32'(dn), 32'h0);
    checkOutput("abort_pass", 32'(mPass), 32'h0);
    checkOutput("abort_result", 32'(mResult), 32'h04);

    // Second start mid-sweep and expected change: sweep unaffected.
    runCustom(8'h24, 10, 12, -1, dc, dn);
    checkOutput("restart_doneCycle", 32'(dc), 32'd25);
    checkOutput("restart_doneCount", 32'(dn), 32'd1);
    checkOutput("restart_pass", 32'(mPass), 32'h1);
    checkOutput("restart_result", 32'(mResult), 32'h24);

    // Abort while in FINISH: done completes and pass is still written.
    runCustom(8'h24, -1, -1, 25, dc, dn);
    checkOutput("finAbort_doneCount", 32'(dn), 32'd1);
    checkOutput("finAbort_pass", 32'(mPass), 32'h1);

    // Asynchronous reset at cycle 14 of a sweep.
    @(negedge clk);
    expReq   = 8'h24;
    startReq = 1'b1;
    @(posedge clk);
    #1 startReq = 1'b0;
    for (int c = 1; c <= 14; c++) @(negedge clk);
    checkOutput("preRst_busy", 32'(mBusy), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRst_stim", 32'(mStim), 32'h0);
    checkOutput("midRst_busy", 32'(mBusy), 32'h0);
    checkOutput("midRst_result", 32'(mResult), 32'h0);
    checkOutput("midRst_pass", 32'(mPass), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h24, 2, dc, dn, se);
    checkOutput("postRst_doneCycle", 32'(dc), 32'd25);
    checkOutput("postRst_pass", 32'(mPass), 32'h1);
    checkOutput("postRst_result", 32'(mResult), 32'h24);

    // SETTLE=1 build.
    @(negedge clk);
    useSettle1 = 1'b1;
    applyStimulus(8'h24, 1, dc, dn, se);
    checkOutput("s1_doneCycle", 32'(dc), 32'd17);
    checkOutput("s1_doneCount", 32'(dn), 32'd1);
    checkOutput("s1_stimSeq", 32'(se), 32'd0);
    checkOutput("s1_pass", 32'(mPass), 32'h1);
    checkOutput("s1_result", 32'(mResult), 32'h24);
    checkOutput("s1_mismatch", 32'(mMismatch), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
